// File: rtl/vq_block_decoder_pkg.sv
// Shared types and helpers for the block vector-quantisation decoder.
// The localparams describe the default 64x64, 1x1-codeword, 64-entry configuration.
package vq_pkg;

    localparam int N     = 1;
    localparam int BX    = 64;
    localparam int NB    = 4096;
    localparam int IDX_W = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TAG   = 2'd1,
        FETCH = 2'd2,
        DONE  = 2'd3
    } vq_state_e;

    // Counter width that never collapses to zero bits for single-value ranges.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic [31:0] calc_pic_addr(
        input logic [31:0] by,
        input logic [31:0] r,
        input logic [31:0] bx,
        input logic [31:0] c,
        input logic [31:0] blk_w,
        input logic [31:0] blk_h,
        input logic [31:0] img_w
    );
        return (by * blk_h + r) * img_w + bx * blk_w + c;
    endfunction

endpackage

// File: rtl/vq_block_decoder_addr_gen.sv
// Block/row/column/element counters walking the picture one codeword at a time,
// producing the tag address, codebook offset and picture address of the current element.
module vq_addr_gen
    import vq_pkg::*;
#(
    parameter int IMG_W  = 64,
    parameter int IMG_H  = 64,
    parameter int BLK_W  = 1,
    parameter int BLK_H  = 1,
    parameter int ADDR_W = 20
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              advance,
    output logic [ADDR_W-1:0] blk_addr,
    output logic [ADDR_W-1:0] cb_off,
    output logic [ADDR_W-1:0] pic_a,
    output logic              first_elem,
    output logic              last_elem,
    output logic              last_blk
);

    localparam int BLK_N   = BLK_W * BLK_H;
    localparam int BLK_X   = IMG_W / BLK_W;
    localparam int BLK_Y   = IMG_H / BLK_H;
    localparam int BLK_NUM = BLK_X * BLK_Y;
    localparam int CW = cnt_w(BLK_W);
    localparam int RW = cnt_w(BLK_H);
    localparam int EW = cnt_w(BLK_N);
    localparam int XW = cnt_w(BLK_X);
    localparam int YW = cnt_w(BLK_Y);
    localparam int BW = cnt_w(BLK_NUM);

    logic [CW-1:0] c_r;
    logic [RW-1:0] r_r;
    logic [EW-1:0] e_r;
    logic [XW-1:0] bx_r;
    logic [YW-1:0] by_r;
    logic [BW-1:0] b_r;
    logic [31:0]   pa_s;
    logic          unused_pa_s;

    // Element counter with row/column split, then block counters in raster order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_r  <= {CW{1'b0}};
            r_r  <= {RW{1'b0}};
            e_r  <= {EW{1'b0}};
            bx_r <= {XW{1'b0}};
            by_r <= {YW{1'b0}};
            b_r  <= {BW{1'b0}};
        end else if (clear) begin
            c_r  <= {CW{1'b0}};
            r_r  <= {RW{1'b0}};
            e_r  <= {EW{1'b0}};
            bx_r <= {XW{1'b0}};
            by_r <= {YW{1'b0}};
            b_r  <= {BW{1'b0}};
        end else if (advance) begin
            if (last_elem) begin
                c_r <= {CW{1'b0}};
                r_r <= {RW{1'b0}};
                e_r <= {EW{1'b0}};
                b_r <= last_blk ? {BW{1'b0}} : b_r + BW'(1'b1);
                if (bx_r == XW'(BLK_X - 1)) begin
                    bx_r <= {XW{1'b0}};
                    by_r <= (by_r == YW'(BLK_Y - 1)) ? {YW{1'b0}} : by_r + YW'(1'b1);
                end else begin
                    bx_r <= bx_r + XW'(1'b1);
                end
            end else begin
                e_r <= e_r + EW'(1'b1);
                if (c_r == CW'(BLK_W - 1)) begin
                    c_r <= {CW{1'b0}};
                    r_r <= r_r + RW'(1'b1);
                end else begin
                    c_r <= c_r + CW'(1'b1);
                end
            end
        end
    end

    assign pa_s = calc_pic_addr(32'(by_r), 32'(r_r), 32'(bx_r), 32'(c_r),
                                32'(BLK_W), 32'(BLK_H), 32'(IMG_W));
    assign unused_pa_s = ^pa_s[31:ADDR_W];

    assign pic_a      = pa_s[ADDR_W-1:0];
    assign blk_addr   = ADDR_W'(b_r);
    assign cb_off     = ADDR_W'(e_r);
    assign first_elem = (e_r == {EW{1'b0}});
    assign last_elem  = (e_r == EW'(BLK_N - 1));
    assign last_blk   = (bx_r == XW'(BLK_X - 1)) && (by_r == YW'(BLK_Y - 1));

endmodule

// File: rtl/vq_block_decoder.sv
// Vector-quantisation decompressor: reads one tag per block, copies the selected
// codeword into the picture RAM at one pixel per cycle, flags out-of-range tags.
module vq_block_decoder
    import vq_pkg::*;
#(
    parameter int IMG_W    = 64,
    parameter int IMG_H    = 64,
    parameter int BLK_W    = 1,
    parameter int BLK_H    = 1,
    parameter int CB_DEPTH = 64,
    parameter int PIX_W    = 24,
    parameter int ADDR_W   = 20
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              tag_err,
    output logic [ADDR_W-1:0] RAM_W_A,
    output logic              RAM_W_OE,
    output logic              RAM_W_WE,
    output logic [PIX_W-1:0]  RAM_W_D,
    input  logic [PIX_W-1:0]  RAM_W_Q,
    output logic [ADDR_W-1:0] RAM_TAG_A,
    output logic              RAM_TAG_OE,
    output logic              RAM_TAG_WE,
    output logic [PIX_W-1:0]  RAM_TAG_D,
    input  logic [PIX_W-1:0]  RAM_TAG_Q,
    output logic [ADDR_W-1:0] RAM_PIC_A,
    output logic              RAM_PIC_OE,
    output logic              RAM_PIC_WE,
    output logic [PIX_W-1:0]  RAM_PIC_D,
    input  logic [PIX_W-1:0]  RAM_PIC_Q
);

    localparam int BLK_N     = BLK_W * BLK_H;
    localparam int TAG_IDX_W = cnt_w(CB_DEPTH);

    vq_state_e             state_r, state_n;
    logic                  accept_s;
    logic                  busy_r, done_r, tag_err_r;
    logic [TAG_IDX_W-1:0]  idx_r, idx_s;
    logic                  blk_err_r, err_s;
    logic                  wr_en_r, wr_err_r;
    logic [ADDR_W-1:0]     wr_addr_r;
    logic [ADDR_W-1:0]     blk_addr_s, cb_off_s, pic_a_s;
    logic                  first_elem_s, last_elem_s, last_blk_s;
    logic                  unused_pic_q_s;

    vq_addr_gen #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .BLK_W  (BLK_W),
        .BLK_H  (BLK_H),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (accept_s),
        .advance    (state_r == FETCH),
        .blk_addr   (blk_addr_s),
        .cb_off     (cb_off_s),
        .pic_a      (pic_a_s),
        .first_elem (first_elem_s),
        .last_elem  (last_elem_s),
        .last_blk   (last_blk_s)
    );

    // Next-state logic; in DONE a restart is taken only once the final write has drained.
    always_comb begin
        state_n  = state_r;
        accept_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_n  = TAG;
                    accept_s = 1'b1;
                end else begin
                    state_n = IDLE;
                end
            end
            TAG: state_n = FETCH;
            FETCH: begin
                if (last_elem_s) begin
                    state_n = last_blk_s ? DONE : TAG;
                end else begin
                    state_n = FETCH;
                end
            end
            DONE: begin
                if (start && done_r) begin
                    state_n  = TAG;
                    accept_s = 1'b1;
                end else begin
                    state_n = DONE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Tag arrives from RAM on the first element of a block; later elements use the held copy.
    always_comb begin
        idx_s = idx_r;
        err_s = blk_err_r;
        if ((state_r == FETCH) && first_elem_s) begin
            idx_s = RAM_TAG_Q[TAG_IDX_W-1:0];
            err_s = |RAM_TAG_Q[PIX_W-1:TAG_IDX_W];
        end else begin
            idx_s = idx_r;
            err_s = blk_err_r;
        end
    end

    // RAM address/enable muxing; addresses park at zero when a port is idle.
    always_comb begin
        RAM_TAG_A  = {ADDR_W{1'b0}};
        RAM_TAG_OE = 1'b0;
        RAM_W_A    = {ADDR_W{1'b0}};
        RAM_W_OE   = 1'b0;
        if (state_r == TAG) begin
            RAM_TAG_A  = blk_addr_s;
            RAM_TAG_OE = 1'b1;
        end else if (state_r == FETCH) begin
            RAM_W_A  = ADDR_W'(idx_s) * ADDR_W'(BLK_N) + cb_off_s;
            RAM_W_OE = 1'b1;
        end else begin
            RAM_TAG_A = {ADDR_W{1'b0}};
            RAM_W_A   = {ADDR_W{1'b0}};
        end
    end

    // FSM state, status flags and the one-cycle write pipeline behind FETCH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            tag_err_r <= 1'b0;
            idx_r     <= {TAG_IDX_W{1'b0}};
            blk_err_r <= 1'b0;
            wr_en_r   <= 1'b0;
            wr_err_r  <= 1'b0;
            wr_addr_r <= {ADDR_W{1'b0}};
        end else begin
            state_r   <= state_n;
            // A FETCH cycle always leaves one write outstanding for the next cycle.
            busy_r    <= (state_n == TAG) || (state_n == FETCH) || (state_r == FETCH);
            done_r    <= (state_n == DONE) && (state_r == DONE);
            idx_r     <= idx_s;
            blk_err_r <= err_s;
            if (accept_s) begin
                tag_err_r <= 1'b0;
            end else if ((state_r == FETCH) && first_elem_s && err_s) begin
                tag_err_r <= 1'b1;
            end
            wr_en_r   <= (state_r == FETCH);
            wr_err_r  <= (state_r == FETCH) ? err_s : 1'b0;
            wr_addr_r <= (state_r == FETCH) ? pic_a_s : {ADDR_W{1'b0}};
        end
    end

    assign busy    = busy_r;
    assign done    = done_r;
    assign tag_err = tag_err_r;

    assign RAM_PIC_A  = wr_addr_r;
    assign RAM_PIC_WE = wr_en_r;
    assign RAM_PIC_OE = 1'b0;
    assign RAM_PIC_D  = (wr_en_r && !wr_err_r) ? RAM_W_Q : {PIX_W{1'b0}};

    assign RAM_W_WE   = 1'b0;
    assign RAM_W_D    = {PIX_W{1'b0}};
    assign RAM_TAG_WE = 1'b0;
    assign RAM_TAG_D  = {PIX_W{1'b0}};

    assign unused_pic_q_s = ^RAM_PIC_Q;

endmodule

// File: tb/tb_vq_block_decoder.sv
// Scoreboard bench for vq_block_decoder: a default 64x64 instance and a 2x2-block 8x8 instance.
module tb_vq_block_decoder;

    typedef struct packed {
        logic [19:0] a;
        logic [23:0] d;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n;
    logic start0, start1;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic        busy0, done0, err0, w_oe0, w_we0, tag_oe0, tag_we0, pic_oe0, pic_we0;
    logic [19:0] w_a0, tag_a0, pic_a0;
    logic [23:0] w_d0, w_q0, tag_d0, tag_q0, pic_d0, pic_q0;
    logic        busy1, done1, err1, w_oe1, w_we1, tag_oe1, tag_we1, pic_oe1, pic_we1;
    logic [19:0] w_a1, tag_a1, pic_a1;
    logic [23:0] w_d1, w_q1, tag_d1, tag_q1, pic_d1, pic_q1;

    logic [23:0] cb0 [64];
    logic [23:0] tag0 [4096];
    logic [23:0] pic0 [4096];
    logic [23:0] cb1 [16];
    logic [23:0] tag1 [16];
    logic [23:0] pic1 [64];
    logic [23:0] expimg [4096];
    wr_t q0[$];
    wr_t q1[$];
    wr_t mon0, mon1;

    vq_block_decoder dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .busy(busy0), .done(done0), .tag_err(err0),
        .RAM_W_A(w_a0), .RAM_W_OE(w_oe0), .RAM_W_WE(w_we0), .RAM_W_D(w_d0), .RAM_W_Q(w_q0),
        .RAM_TAG_A(tag_a0), .RAM_TAG_OE(tag_oe0), .RAM_TAG_WE(tag_we0), .RAM_TAG_D(tag_d0),
        .RAM_TAG_Q(tag_q0), .RAM_PIC_A(pic_a0), .RAM_PIC_OE(pic_oe0), .RAM_PIC_WE(pic_we0),
        .RAM_PIC_D(pic_d0), .RAM_PIC_Q(pic_q0)
    );

    vq_block_decoder #(.IMG_W(8), .IMG_H(8), .BLK_W(2), .BLK_H(2), .CB_DEPTH(4),
                       .PIX_W(24), .ADDR_W(20)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1), .done(done1), .tag_err(err1),
        .RAM_W_A(w_a1), .RAM_W_OE(w_oe1), .RAM_W_WE(w_we1), .RAM_W_D(w_d1), .RAM_W_Q(w_q1),
        .RAM_TAG_A(tag_a1), .RAM_TAG_OE(tag_oe1), .RAM_TAG_WE(tag_we1), .RAM_TAG_D(tag_d1),
        .RAM_TAG_Q(tag_q1), .RAM_PIC_A(pic_a1), .RAM_PIC_OE(pic_oe1), .RAM_PIC_WE(pic_we1),
        .RAM_PIC_D(pic_d1), .RAM_PIC_Q(pic_q1)
    );

    // Single-port RAM models with one-cycle read latency.
    always @(posedge clk) begin
        if (w_oe0) w_q0 <= cb0[w_a0[5:0]];
        if (tag_oe0) tag_q0 <= tag0[tag_a0[11:0]];
        if (pic_we0) pic0[pic_a0[11:0]] <= pic_d0;
        if (w_oe1) w_q1 <= cb1[w_a1[3:0]];
        if (tag_oe1) tag_q1 <= tag1[tag_a1[3:0]];
        if (pic_we1) pic1[pic_a1[5:0]] <= pic_d1;
    end
    assign pic_q0 = 24'h0;
    assign pic_q1 = 24'h0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitors: every picture write must match the next expected write of that instance.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("d0_ram_ctrl", {59'd0, w_we0, tag_we0, pic_oe0, |w_d0, |tag_d0}, 64'd0);
            chk("d1_ram_ctrl", {59'd0, w_we1, tag_we1, pic_oe1, |w_d1, |tag_d1}, 64'd0);
            if (pic_we0) begin
                if (q0.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL d0_unexpected_write addr=%0h data=%0h", pic_a0, pic_d0);
                end else begin
                    mon0 = q0.pop_front();
                    chk("d0_wr_addr", 64'(pic_a0), 64'(mon0.a));
                    chk("d0_wr_data", 64'(pic_d0), 64'(mon0.d));
                    chk("d0_addr_range", 64'(pic_a0 < 20'd4096), 64'd1);
                end
            end
            if (pic_we1) begin
                if (q1.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL d1_unexpected_write addr=%0h data=%0h", pic_a1, pic_d1);
                end else begin
                    mon1 = q1.pop_front();
                    chk("d1_wr_addr", 64'(pic_a1), 64'(mon1.a));
                    chk("d1_wr_data", 64'(pic_d1), 64'(mon1.d));
                    chk("d1_addr_range", 64'(pic_a1 < 20'd64), 64'd1);
                end
            end
        end
    end

    // Reference: walk blocks in raster order, expand each tag into its codeword pixels.
    task automatic model(input int sel, output bit err);
        int iw, bw, bh, cbd, n, bxn, nb, bx, by, a, t;
        logic [23:0] d;
        wr_t w;
        iw = (sel == 0) ? 64 : 8;
        bw = (sel == 0) ? 1 : 2;
        bh = bw;
        cbd = (sel == 0) ? 64 : 4;
        n = bw * bh;
        bxn = iw / bw;
        nb = bxn * (iw / bh);
        err = 1'b0;
        for (int b = 0; b < nb; b++) begin
            bx = b % bxn;
            by = b / bxn;
            t = (sel == 0) ? int'(tag0[b]) : int'(tag1[b]);
            for (int r = 0; r < bh; r++) begin
                for (int c = 0; c < bw; c++) begin
                    a = (by * bh + r) * iw + bx * bw + c;
                    if (t >= cbd) begin
                        d = 24'h0;
                        err = 1'b1;
                    end else begin
                        d = (sel == 0) ? cb0[t * n + r * bw + c] : cb1[t * n + r * bw + c];
                    end
                    expimg[a] = d;
                    w.a = 20'(a);
                    w.d = d;
                    if (sel == 0) q0.push_back(w); else q1.push_back(w);
                end
            end
        end
    endtask

    task automatic do_run(input int sel, input int inj_cyc);
        bit experr;
        int tgt, cyc, mism, npix;
        bit seen;
        string pfx;
        pfx = (sel == 0) ? "d0" : "d1";
        model(sel, experr);
        tgt = (sel == 0) ? 8194 : 82;
        npix = (sel == 0) ? 4096 : 64;
        @(negedge clk);
        if (sel == 0) start0 = 1'b1; else start1 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        start1 = 1'b0;
        seen = 1'b0;
        cyc = 1;
        while (cyc <= tgt + 20) begin
            @(negedge clk);
            if (cyc == 1)
                chk({pfx, "_start_ack"}, (sel == 0) ? {61'd0, busy0, done0, err0} : {61'd0, busy1, done1, err1}, 64'd4);
            if (cyc == inj_cyc) begin
                if (sel == 0) start0 = 1'b1; else start1 = 1'b1;
            end else begin
                start0 = 1'b0;
                start1 = 1'b0;
            end
            if ((sel == 0) ? done0 : done1) begin
                seen = 1'b1;
                break;
            end
            cyc++;
        end
        start0 = 1'b0;
        start1 = 1'b0;
        chk({pfx, "_done_cycle"}, 64'(cyc), 64'(tgt));
        chk({pfx, "_done_seen"}, 64'(seen), 64'd1);
        chk({pfx, "_busy_at_done"}, 64'((sel == 0) ? busy0 : busy1), 64'd0);
        chk({pfx, "_tag_err"}, 64'((sel == 0) ? err0 : err1), 64'(experr));
        chk({pfx, "_pending_writes"}, 64'((sel == 0) ? q0.size() : q1.size()), 64'd0);
        repeat (3) @(negedge clk);
        chk({pfx, "_done_held"}, 64'((sel == 0) ? done0 : done1), 64'd1);
        mism = 0;
        for (int i = 0; i < npix; i++)
            if (((sel == 0) ? pic0[i] : pic1[i]) !== expimg[i]) mism++;
        chk({pfx, "_image"}, 64'(mism), 64'd0);
        q0.delete();
        q1.delete();
    endtask

    task automatic chk_reset_outputs(input string name);
        chk(name, 64'(|{busy0, done0, err0, w_a0, w_oe0, w_we0, w_d0, tag_a0, tag_oe0, tag_we0,
                        tag_d0, pic_a0, pic_oe0, pic_we0, pic_d0,
                        busy1, done1, err1, w_a1, w_oe1, w_we1, w_d1, tag_a1, tag_oe1, tag_we1,
                        tag_d1, pic_a1, pic_oe1, pic_we1, pic_d1}), 64'd0);
    endtask

    int pat[8] = '{3, 0, 1, 2, 2, 1, 0, 3};

    initial begin
        rst_n = 1'b1;
        start0 = 1'b0;
        start1 = 1'b0;
        for (int k = 0; k < 64; k++) cb0[k] = {3{8'(k)}};
        for (int i = 0; i < 4096; i++) tag0[i] = 24'(i % 64);
        for (int i = 0; i < 4096; i++) pic0[i] = 24'h0;
        for (int a = 0; a < 16; a++) cb1[a] = 24'(a);
        for (int i = 0; i < 16; i++) tag1[i] = 24'(pat[i % 8]);
        for (int i = 0; i < 64; i++) pic1[i] = 24'h0;
        #1 rst_n = 1'b0;
        #2 chk_reset_outputs("reset_outputs");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Small configuration, fixed pattern then randomised tables.
        do_run(1, 0);
        chk("d1_pic0", 64'(pic1[0]), 64'd12);
        chk("d1_pic1", 64'(pic1[1]), 64'd13);
        chk("d1_pic8", 64'(pic1[8]), 64'd14);
        chk("d1_pic9", 64'(pic1[9]), 64'd15);
        chk("d1_blk10_first", 64'(pic1[2]), 64'd0);
        chk("d1_blk10_last", 64'(pic1[11]), 64'd3);
        for (int run = 0; run < 8; run++) begin
            for (int a = 0; a < 16; a++) cb1[a] = 24'($urandom);
            for (int i = 0; i < 16; i++)
                tag1[i] = ($urandom_range(0, 9) == 0) ? (24'($urandom) | 24'h4) : 24'($urandom_range(0, 3));
            do_run(1, (run % 2 == 0) ? 40 : 0);
        end

        // Default configuration: pattern with a start pulse while busy.
        do_run(0, 100);
        chk("d0_pic100", 64'(pic0[100]), 64'h242424);
        chk("d0_pic4095", 64'(pic0[4095]), 64'h3f3f3f);

        // Out-of-range tag at block 5, restarted from DONE.
        tag0[5] = 24'h000040;
        do_run(0, 0);
        chk("d0_err_pixel", 64'(pic0[5]), 64'd0);
        chk("d0_err_neighbour", 64'(pic0[6]), 64'h060606);
        chk("d0_err_flag_pre_restart", 64'(err0), 64'd1);
        tag0[5] = 24'h000005;
        do_run(0, 0);

        // Reset in the middle of a run, then a randomised run must rebuild the picture.
        begin
            bit dummy;
            model(0, dummy);
            @(negedge clk);
            start0 = 1'b1;
            @(posedge clk);
            #1 start0 = 1'b0;
            repeat (3000) @(posedge clk);
            #2 rst_n = 1'b0;
            #1 chk_reset_outputs("midrun_reset_outputs");
            q0.delete();
            repeat (2) @(negedge clk);
            chk_reset_outputs("held_reset_outputs");
            rst_n = 1'b1;
        end
        for (int k = 0; k < 64; k++) cb0[k] = 24'($urandom);
        for (int i = 0; i < 4096; i++)
            tag0[i] = ($urandom_range(0, 49) == 0) ? (24'($urandom) | 24'h40) : 24'($urandom_range(0, 63));
        do_run(0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
